ftq_commit_queue: RTL

Frontend fetch target queue that is the receiving end of the backend commit/flush interface. It buffers fetch blocks predicted by the BPU, hands them in order to the IFU tagged with an FTQ ID, retires them when the backend reports committed basic blocks, and rolls back all younger blocks on a backend flush to a given FTQ ID. Retired blocks are reported one cycle later for BPU training.

---
 rtl/ftq_commit_queue_pkg.sv | 18 +
 rtl/ftq_commit_queue_entry_ram.sv | 38 +++
 rtl/ftq_commit_queue.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/ftq_commit_queue_pkg.sv
// ftq_commit_queue_pkg
//   Shared types and default sizing for the frontend fetch target queue.
//   FTQ_SIZE_CFG / COMMIT_WIDTH_CFG mirror the core-wide frontend FTQ size
//   and the backend commit width; the queue takes them as parameter defaults.
//   ftq_block_t is one predicted fetch block as produced by the BPU.
package ftq_commit_queue_pkg;

  localparam int FTQ_SIZE_CFG     = 8;
  localparam int COMMIT_WIDTH_CFG = 2;

  typedef struct packed {
    logic [31:0] start_pc;
    logic [2:0]  length;
    logic        taken;
    logic [31:0] target;
  } ftq_block_t;

endpackage

// File: rtl/ftq_commit_queue_entry_ram.sv
// ftq_commit_queue_entry_ram
//   Entry storage for the fetch target queue: one synchronous write port,
//   one combinational read port for the IFU and NRD combinational read ports
//   for the commit lanes.
//   Ports:
//     clk                    clock
//     we_i/waddr_i/wdata_i   write enable, address, block
//     ifu_raddr_i/_rdata_o   IFU read address / block
//     cm_raddr_i/cm_rdata_o  per-commit-lane read address / block
module ftq_commit_queue_entry_ram
  import ftq_commit_queue_pkg::*;
#(
  parameter int DEPTH = 8,
  parameter int NRD   = 2,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic                    clk,
  input  logic                    we_i,
  input  logic [AW-1:0]           waddr_i,
  input  ftq_block_t              wdata_i,
  input  logic [AW-1:0]           ifu_raddr_i,
  output ftq_block_t              ifu_rdata_o,
  input  logic [NRD-1:0][AW-1:0]  cm_raddr_i,
  output ftq_block_t [NRD-1:0]    cm_rdata_o
);

  ftq_block_t mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  always_comb begin
    ifu_rdata_o = mem_q[ifu_raddr_i];
    for (int i = 0; i < NRD; i++) cm_rdata_o[i] = mem_q[cm_raddr_i[i]];
  end

endmodule

// File: rtl/ftq_commit_queue.sv
// ftq_commit_queue
//   Fetch target queue on the frontend side of the backend commit/flush
//   interface. Buffers BPU fetch blocks, issues them in order to the IFU with
//   an FTQ ID, retires committed blocks (reported one cycle later for BPU
//   training) and rolls back younger blocks on a backend flush.
//   Ports:
//     clk, rst                       clock, synchronous active-high reset
//     bpu_valid_i/ready_o/block_i    BPU enqueue channel
//     ifu_valid_o/ready_i/block_o    IFU issue channel, ifu_ftq_id_o = ID
//     backend_commit_block_i         one bit per committed block (any pattern)
//     backend_flush_i/_ftq_id_i      flush; the named entry survives
//     commit_valid_o/commit_block_o  registered retire report, lane 0 oldest
//     full_o, empty_o                occupancy flags from the registered count
//
//   Handshakes: a transfer happens on a rising edge where valid and ready are
//   both high; valid never depends on ready of the same channel, and a
//   backend flush drops both bpu_ready_o and ifu_valid_o for that cycle.
module ftq_commit_queue
  import ftq_commit_queue_pkg::*;
#(
  parameter int FTQ_SIZE     = FTQ_SIZE_CFG,
  parameter int COMMIT_WIDTH = COMMIT_WIDTH_CFG,
  parameter int ID_W         = $clog2(FTQ_SIZE)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            bpu_valid_i,
  output logic                            bpu_ready_o,
  input  ftq_block_t                      bpu_block_i,
  output logic                            ifu_valid_o,
  input  logic                            ifu_ready_i,
  output ftq_block_t                      ifu_block_o,
  output logic [ID_W-1:0]                 ifu_ftq_id_o,
  input  logic [COMMIT_WIDTH-1:0]         backend_commit_block_i,
  input  logic                            backend_flush_i,
  input  logic [ID_W-1:0]                 backend_flush_ftq_id_i,
  output logic [COMMIT_WIDTH-1:0]         commit_valid_o,
  output ftq_block_t [COMMIT_WIDTH-1:0]   commit_block_o,
  output logic                            full_o,
  output logic                            empty_o
);

  localparam int CNT_W = ID_W + 1;

  logic [ID_W-1:0]  bpu_ptr_q, bpu_ptr_d;
  logic [ID_W-1:0]  ifu_ptr_q, ifu_ptr_d;
  logic [ID_W-1:0]  comm_ptr_q, comm_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  // Entries enqueued but not yet issued; distinguishes "full, nothing sent"
  // from "full, everything sent" when ifu_ptr == bpu_ptr.
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [COMMIT_WIDTH-1:0]       commit_valid_q, commit_valid_d;
  ftq_block_t [COMMIT_WIDTH-1:0] commit_block_q, commit_block_d;

  logic                          enq_fire;
  logic                          iss_fire;
  logic [CNT_W-1:0]              n_commit;
  logic [ID_W-1:0]               flush_dist;
  logic [COMMIT_WIDTH-1:0][ID_W-1:0] cm_raddr;
  ftq_block_t [COMMIT_WIDTH-1:0] cm_rdata;

  ftq_commit_queue_entry_ram #(
    .DEPTH (FTQ_SIZE),
    .NRD   (COMMIT_WIDTH),
    .AW    (ID_W)
  ) u_entry_ram (
    .clk         (clk),
    .we_i        (enq_fire),
    .waddr_i     (bpu_ptr_q),
    .wdata_i     (bpu_block_i),
    .ifu_raddr_i (ifu_ptr_q),
    .ifu_rdata_o (ifu_block_o),
    .cm_raddr_i  (cm_raddr),
    .cm_rdata_o  (cm_rdata)
  );

  always_comb begin
    full_o       = (count_q == CNT_W'(FTQ_SIZE));
    empty_o      = (count_q == '0);
    bpu_ready_o  = !full_o && !backend_flush_i;
    ifu_valid_o  = (pend_q != '0) && !backend_flush_i;
    ifu_ftq_id_o = ifu_ptr_q;
    enq_fire     = bpu_valid_i && bpu_ready_o;
    iss_fire     = ifu_valid_o && ifu_ready_i;
    flush_dist   = backend_flush_ftq_id_i - comm_ptr_q;

    // Any commit pattern retires popcount entries, oldest first.
    n_commit = '0;
    for (int i = 0; i < COMMIT_WIDTH; i++) begin
      n_commit = n_commit + CNT_W'(backend_commit_block_i[i]);
    end
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      cm_raddr[j] = comm_ptr_q + ID_W'(j);
    end
  end

  always_comb begin
    comm_ptr_d = comm_ptr_q + ID_W'(n_commit);
    // Retired blocks are compacted into the low lanes.
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      commit_valid_d[j] = (CNT_W'(j) < n_commit);
      commit_block_d[j] = commit_valid_d[j] ? cm_rdata[j] : '0;
    end

    if (backend_flush_i) begin
      // Keep [comm_ptr, flush_id]; everything younger is dropped and
      // both the BPU and IFU resume right after the flushing block.
      bpu_ptr_d = backend_flush_ftq_id_i + ID_W'(1);
      ifu_ptr_d = backend_flush_ftq_id_i + ID_W'(1);
      count_d   = CNT_W'(flush_dist) + CNT_W'(1) - n_commit;
      pend_d    = '0;
    end else begin
      bpu_ptr_d = bpu_ptr_q + ID_W'(enq_fire);
      ifu_ptr_d = ifu_ptr_q + ID_W'(iss_fire);
      count_d   = count_q + CNT_W'(enq_fire) - n_commit;
      pend_d    = pend_q + CNT_W'(enq_fire) - CNT_W'(iss_fire);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      bpu_ptr_q      <= '0;
      ifu_ptr_q      <= '0;
      comm_ptr_q     <= '0;
      count_q        <= '0;
      pend_q         <= '0;
      commit_valid_q <= '0;
      commit_block_q <= '0;
    end else begin
      bpu_ptr_q      <= bpu_ptr_d;
      ifu_ptr_q      <= ifu_ptr_d;
      comm_ptr_q     <= comm_ptr_d;
      count_q        <= count_d;
      pend_q         <= pend_d;
      commit_valid_q <= commit_valid_d;
      commit_block_q <= commit_block_d;
    end
  end

  assign commit_valid_o = commit_valid_q;
  assign commit_block_o = commit_block_q;

  // Backend protocol violations; the queue does not recover from these.
  a_commit_le_count: assert property (@(posedge clk) disable iff (rst)
    n_commit <= count_q);
  a_commit_sent_only: assert property (@(posedge clk) disable iff (rst)
    n_commit <= (count_q - pend_q));
  a_flush_in_range: assert property (@(posedge clk) disable iff (rst)
    backend_flush_i |-> (CNT_W'(flush_dist) < count_q));

endmodule
